stopwatch_ctrl: RTL and testbench

Stopwatch controller that sequences four cascaded BCD digit counters in mm:ss format. The digits are seconds ones (mod-10), seconds tens (mod-6), minutes ones (mod-10) and minutes tens (mod-6). An internal prescaler turns the system clock into count ticks. A start/stop and lap/reset command FSM gates those ticks and freezes the display. The block sits between debounced button pulses and the 7-segment display driver.

---
 rtl/stopwatch_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   mm:ss stopwatch controller. A prescaler divides the system clock into count
//   ticks, which advance four cascaded BCD digits (sec ones/tens, min ones/tens).
//   A command FSM (IDLE/RUN/LAP/PAUSE) driven by debounced button pulses gates
//   the ticks and selects between the live count and a lap snapshot.
//
// Ports:
//   clk         system clock, rising-edge active
//   rst         asynchronous reset, active-high
//   start_stop  single-cycle command pulse (start / pause / resume)
//   lap_reset   single-cycle command pulse (lap freeze / release / clear)
//   sec_ones    displayed seconds ones, BCD 0..9
//   sec_tens    displayed seconds tens, BCD 0..5
//   min_ones    displayed minutes ones, BCD 0..9
//   min_tens    displayed minutes tens, BCD 0..5
//   running     high in RUN and LAP
//   lap_active  high in LAP
//   rollover    one-cycle pulse when the count wraps 59:59 -> 00:00
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       lap_reset,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       lap_active,
    output logic       rollover
);

    localparam int unsigned PRE_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DIGIT_W  = 4;

    localparam logic [PRE_W-1:0]   PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [DIGIT_W-1:0] NINE    = DIGIT_W'(9);
    localparam logic [DIGIT_W-1:0] FIVE    = DIGIT_W'(5);
    localparam logic [DIGIT_W-1:0] ONE     = DIGIT_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_LAP   = 2'd2;
    localparam logic [1:0] ST_PAUSE = 2'd3;

    // State, prescaler and rollover pulse
    logic [1:0]         state_q, state_d;
    logic [PRE_W-1:0]   pre_q,   pre_d;
    logic               roll_q,  roll_d;

    // Live digits
    logic [DIGIT_W-1:0] so_q, so_d;
    logic [DIGIT_W-1:0] st_q, st_d;
    logic [DIGIT_W-1:0] mo_q, mo_d;
    logic [DIGIT_W-1:0] mt_q, mt_d;

    // Lap snapshot digits
    logic [DIGIT_W-1:0] snap_so_q, snap_so_d;
    logic [DIGIT_W-1:0] snap_st_q, snap_st_d;
    logic [DIGIT_W-1:0] snap_mo_q, snap_mo_d;
    logic [DIGIT_W-1:0] snap_mt_q, snap_mt_d;

    // Ticked-forward live digits, used whenever a tick lands this cycle
    logic [DIGIT_W-1:0] so_inc, st_inc, mo_inc, mt_inc;
    logic               wrap_all;

    logic counting;
    logic tick;

    assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign tick     = counting && (pre_q == PRE_MAX);

    // BCD cascade: each digit carries into the next only when it wraps
    always_comb begin
        so_inc   = so_q;
        st_inc   = st_q;
        mo_inc   = mo_q;
        mt_inc   = mt_q;
        wrap_all = 1'b0;
        if (so_q >= NINE) begin
            so_inc = '0;
            if (st_q >= FIVE) begin
                st_inc = '0;
                if (mo_q >= NINE) begin
                    mo_inc = '0;
                    if (mt_q >= FIVE) begin
                        mt_inc   = '0;
                        wrap_all = 1'b1;
                    end else begin
                        mt_inc = mt_q + ONE;
                    end
                end else begin
                    mo_inc = mo_q + ONE;
                end
            end else begin
                st_inc = st_q + ONE;
            end
        end else begin
            so_inc = so_q + ONE;
        end
    end

    // Next-state: prescaler, digits, snapshot and command FSM
    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        roll_d    = 1'b0;
        so_d      = so_q;
        st_d      = st_q;
        mo_d      = mo_q;
        mt_d      = mt_q;
        snap_so_d = snap_so_q;
        snap_st_d = snap_st_q;
        snap_mo_d = snap_mo_q;
        snap_mt_d = snap_mt_q;

        if (counting) begin
            pre_d = tick ? '0 : pre_q + PRE_W'(1);
        end

        if (tick) begin
            so_d   = so_inc;
            st_d   = st_inc;
            mo_d   = mo_inc;
            mt_d   = mt_inc;
            roll_d = wrap_all;
        end

        // start_stop has priority; a simultaneous lap_reset is dropped
        case (state_q)
            ST_IDLE: begin
                if (start_stop) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (start_stop) begin
                    state_d = ST_PAUSE;
                end else if (lap_reset) begin
                    state_d   = ST_LAP;
                    // Snapshot is the pre-tick live value
                    snap_so_d = so_q;
                    snap_st_d = st_q;
                    snap_mo_d = mo_q;
                    snap_mt_d = mt_q;
                end
            end
            ST_LAP: begin
                if (start_stop) begin
                    state_d = ST_PAUSE;
                end else if (lap_reset) begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (start_stop) begin
                    state_d = ST_RUN;
                end else if (lap_reset) begin
                    state_d = ST_IDLE;
                    pre_d   = '0;
                    so_d    = '0;
                    st_d    = '0;
                    mo_d    = '0;
                    mt_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            roll_q    <= 1'b0;
            so_q      <= '0;
            st_q      <= '0;
            mo_q      <= '0;
            mt_q      <= '0;
            snap_so_q <= '0;
            snap_st_q <= '0;
            snap_mo_q <= '0;
            snap_mt_q <= '0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            roll_q    <= roll_d;
            so_q      <= so_d;
            st_q      <= st_d;
            mo_q      <= mo_d;
            mt_q      <= mt_d;
            snap_so_q <= snap_so_d;
            snap_st_q <= snap_st_d;
            snap_mo_q <= snap_mo_d;
            snap_mt_q <= snap_mt_d;
        end
    end

    // Display selects the frozen snapshot only while in LAP
    assign sec_ones   = (state_q == ST_LAP) ? snap_so_q : so_q;
    assign sec_tens   = (state_q == ST_LAP) ? snap_st_q : st_q;
    assign min_ones   = (state_q == ST_LAP) ? snap_mo_q : mo_q;
    assign min_tens   = (state_q == ST_LAP) ? snap_mt_q : mt_q;

    assign running    = counting;
    assign lap_active = (state_q == ST_LAP);
    assign rollover   = roll_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Directed self-checking bench for stopwatch_ctrl with TICK_DIV = 4.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
//   Display is compared as a packed BCD word {min_tens,min_ones,sec_tens,sec_ones}.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int unsigned TICK_DIV = 4;

    logic       clk;
    logic       rst;
    logic       start_stop;
    logic       lap_reset;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, lap_active, rollover;
    logic [15:0] disp;

    int checks;
    int errors;

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .lap_reset  (lap_reset),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .running    (running),
        .lap_active (lap_active),
        .rollover   (rollover)
    );

    assign disp = {min_tens, min_ones, sec_tens, sec_ones};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, landing 1 unit after the last one
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic ss, input logic lr);
        start_stop = ss;
        lap_reset  = lr;
        cycles(1);
        start_stop = 1'b0;
        lap_reset  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        start_stop = 1'b0;
        lap_reset  = 1'b0;

        // Reset state
        #1;
        do_reset();
        chk("reset_disp",  disp, 16'h0000);
        chk("reset_run",   16'(running), 16'h0);
        chk("reset_lap",   16'(lap_active), 16'h0);
        chk("reset_roll",  16'(rollover), 16'h0);

        // lap_reset ignored in IDLE, no counting
        pulse(1'b0, 1'b1);
        cycles(10);
        chk("idle_disp",   disp, 16'h0000);
        chk("idle_run",    16'(running), 16'h0);
        chk("idle_lap",    16'(lap_active), 16'h0);

        // First tick after 4 edges, 00:10 after 40
        pulse(1'b1, 1'b0);                 // edge 0
        chk("start_run",   16'(running), 16'h1);
        cycles(3);                         // edge 3
        chk("pre_tick",    disp, 16'h0000);
        cycles(1);                         // edge 4
        chk("first_tick",  disp, 16'h0001);
        cycles(36);                        // edge 40
        chk("ten_sec",     disp, 16'h0010);
        chk("ten_run",     16'(running), 16'h1);

        // Full wrap 59:59 -> 00:00
        do_reset();
        pulse(1'b1, 1'b0);                 // edge 0
        cycles(14396);                     // tick 3599
        chk("max_disp",    disp, 16'h5959);
        chk("max_roll",    16'(rollover), 16'h0);
        cycles(4);                         // tick 3600
        chk("wrap_disp",   disp, 16'h0000);
        chk("wrap_roll",   16'(rollover), 16'h1);
        chk("wrap_run",    16'(running), 16'h1);
        cycles(1);
        chk("roll_clear",  16'(rollover), 16'h0);
        cycles(3);                         // tick 3601
        chk("after_wrap",  disp, 16'h0001);

        // Pause holds prescaler and display, resume continues from held value
        do_reset();
        pulse(1'b1, 1'b0);                 // edge 0
        cycles(5);                         // edge 5, 00:01, pre=1
        pulse(1'b1, 1'b0);                 // edge 6, pre=2, PAUSE
        chk("pause_run",   16'(running), 16'h0);
        chk("pause_disp",  disp, 16'h0001);
        cycles(20);
        chk("pause_hold",  disp, 16'h0001);
        chk("pause_run2",  16'(running), 16'h0);
        pulse(1'b1, 1'b0);                 // resume, pre=2
        chk("resume_run",  16'(running), 16'h1);
        cycles(1);                         // pre=3
        chk("resume_1",    disp, 16'h0001);
        cycles(1);                         // tick
        chk("resume_2",    disp, 16'h0002);

        // Lap freezes display while live count continues
        do_reset();
        pulse(1'b1, 1'b0);                 // edge 0
        cycles(20);                        // edge 20, 00:05
        chk("lap_pre",     disp, 16'h0005);
        pulse(1'b0, 1'b1);                 // edge 21, LAP
        chk("lap_act",     16'(lap_active), 16'h1);
        chk("lap_run",     16'(running), 16'h1);
        chk("lap_disp",    disp, 16'h0005);
        cycles(12);                        // edge 33, live 00:08
        chk("lap_frozen",  disp, 16'h0005);
        pulse(1'b0, 1'b1);                 // edge 34, RUN
        chk("lap_rel",     disp, 16'h0008);
        chk("lap_off",     16'(lap_active), 16'h0);
        cycles(1);                         // edge 35
        pulse(1'b0, 1'b1);                 // edge 36: tick + lap
        chk("lap_tick_snap", disp, 16'h0008);
        chk("lap_tick_act",  16'(lap_active), 16'h1);
        pulse(1'b0, 1'b1);                 // edge 37
        chk("lap_tick_live", disp, 16'h0009);

        // lap_reset from PAUSE clears to IDLE
        do_reset();
        pulse(1'b1, 1'b0);                 // edge 0
        cycles(28);                        // edge 28, 00:07
        pulse(1'b1, 1'b0);                 // edge 29, PAUSE
        chk("p7_disp",     disp, 16'h0007);
        pulse(1'b0, 1'b1);                 // edge 30, IDLE
        chk("clr_disp",    disp, 16'h0000);
        chk("clr_run",     16'(running), 16'h0);
        cycles(8);
        chk("clr_hold",    disp, 16'h0000);

        // lap_reset in RUN does not clear; simultaneous commands -> PAUSE
        pulse(1'b1, 1'b0);                 // edge 0, RUN, pre=0
        cycles(8);                         // edge 8, 00:02
        pulse(1'b0, 1'b1);                 // edge 9, LAP
        chk("run_lr_disp", disp, 16'h0002);
        chk("run_lr_lap",  16'(lap_active), 16'h1);
        pulse(1'b0, 1'b1);                 // edge 10, RUN
        pulse(1'b1, 1'b1);                 // edge 11, PAUSE, pre=3
        chk("both_run",    16'(running), 16'h0);
        chk("both_lap",    16'(lap_active), 16'h0);
        chk("both_disp",   disp, 16'h0002);
        pulse(1'b1, 1'b0);                 // edge 12, RUN, pre held at 3
        pulse(1'b1, 1'b0);                 // edge 13: tick then PAUSE
        chk("tick_ss_disp", disp, 16'h0003);
        chk("tick_ss_run",  16'(running), 16'h0);

        // Asynchronous reset mid-run
        do_reset();
        pulse(1'b1, 1'b0);                 // edge 0
        cycles(3016);                      // 754 ticks = 12:34
        chk("at_1234",     disp, 16'h1234);
        #2;
        rst = 1'b1;
        #1;
        chk("async_disp",  disp, 16'h0000);
        chk("async_run",   16'(running), 16'h0);
        cycles(2);
        rst = 1'b0;
        cycles(10);
        chk("post_disp",   disp, 16'h0000);
        chk("post_run",    16'(running), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
